// File: rtl/ff_fifo_rr_drain_arbiter_if.sv
// Bundle between the source FIFOs, the drain arbiter and the downstream consumer.
// The master modport is the arbiter side; the slave modport is the FIFO/consumer side.
interface ff_fifo_rr_drain_arbiter_if #(
  parameter int n_ports = 4,
  parameter int width   = 8
);
  localparam int PW = (n_ports > 1) ? $clog2(n_ports) : 1;

  logic [n_ports-1:0]       fifo_empty;
  logic [n_ports*width-1:0] fifo_read_data;
  logic [n_ports-1:0]       fifo_pop;
  logic                     down_valid;
  logic                     down_ready;
  logic [width-1:0]         down_data;
  logic [PW-1:0]            down_port;

  modport master (
    input  fifo_empty, fifo_read_data, down_ready,
    output fifo_pop, down_valid, down_data, down_port
  );

  modport slave (
    output fifo_empty, fifo_read_data, down_ready,
    input  fifo_pop, down_valid, down_data, down_port
  );
endinterface

// File: rtl/ff_fifo_rr_drain_arbiter.sv
// Round-robin drain of n_ports show-ahead FIFOs into one registered, port-tagged valid/ready stream.
// Optional macro ARB_BURST_EN lets a granted port keep priority for up to max_burst beats.
module ff_fifo_rr_drain_arbiter #(
  parameter int n_ports   = 4,
  parameter int width     = 8,
  parameter int max_burst = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ff_fifo_rr_drain_arbiter_if.master    bus
);
  localparam int PW = (n_ports > 1) ? $clog2(n_ports) : 1;

  if (n_ports < 2) begin : g_chk_ports
    $error("n_ports must be >= 2");
  end
  if (max_burst < 1) begin : g_chk_burst
    $error("max_burst must be >= 1");
  end

  logic             down_valid_q, down_valid_d;
  logic [width-1:0] down_data_q,  down_data_d;
  logic [PW-1:0]    down_port_q,  down_port_d;
  logic [PW-1:0]    last_grant_q, last_grant_d;

  logic             out_free;
  logic             grant;
  logic [PW-1:0]    winner;
  logic [PW:0]      rr;
  logic [n_ports-1:0] pop;

  // First requesting port after 'after', wrapping; MSB flags that one was found.
  function automatic logic [PW:0] rr_scan(input logic [n_ports-1:0] nonempty,
                                          input logic [PW-1:0]      after);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = n_ports; k >= 1; k--) begin
      idx = (int'(after) + k) % n_ports;
      if (nonempty[idx]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  assign out_free = !down_valid_q || bus.down_ready;
  assign rr       = rr_scan(~bus.fifo_empty, last_grant_q);

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(max_burst + 1);
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          hold;

  // burst_cnt of zero means no grant since reset, so rotation starts at port 0.
  assign hold   = (burst_cnt_q != '0) && (burst_cnt_q < CW'(max_burst))
                  && !bus.fifo_empty[last_grant_q];
  assign winner = hold ? last_grant_q : rr[PW-1:0];
  assign grant  = out_free && (hold || rr[PW]);

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (grant) burst_cnt_d = hold ? (burst_cnt_q + 1'b1) : CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end
`else
  assign winner = rr[PW-1:0];
  assign grant  = out_free && rr[PW];
`endif

  always_comb begin
    pop = '0;
    if (grant && rst_n) pop[winner] = 1'b1;
  end
  assign bus.fifo_pop = pop;

  always_comb begin
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_port_d  = down_port_q;
    last_grant_d = last_grant_q;
    if (grant) begin
      down_valid_d = 1'b1;
      down_data_d  = bus.fifo_read_data[winner*width +: width];
      down_port_d  = winner;
      last_grant_d = winner;
    end else if (out_free) begin
      down_valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_port_q  <= '0;
      last_grant_q <= PW'(n_ports - 1);
    end else begin
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_port_q  <= down_port_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.down_valid = down_valid_q;
  assign bus.down_data  = down_data_q;
  assign bus.down_port  = down_port_q;
endmodule

// File: tb/tb_ff_fifo_rr_drain_arbiter.sv
// Bench for ff_fifo_rr_drain_arbiter: queue-based FIFO emulation, behavioural arbiter model,
// per-port scoreboard and directed literal scenarios followed by randomized traffic.
module tb_ff_fifo_rr_drain_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ff_fifo_rr_drain_arbiter_if #(.n_ports(N), .width(W)) intf ();

  ff_fifo_rr_drain_arbiter #(.n_ports(N), .width(W), .max_burst(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  int tests = 0;
  int fails = 0;

  logic [W-1:0] fq   [N][$];
  logic [W-1:0] sb   [N][$];
  logic [W-1:0] pend [N][$];
  logic         ready_r;

  logic         m_valid, m_nvalid;
  logic [W-1:0] m_data,  m_ndata;
  int           m_port, m_nport, m_last, m_nlast, m_cnt, m_ncnt, m_popidx;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_port = 0; m_last = N - 1; m_cnt = 0;
    m_nvalid = 1'b0; m_ndata = '0; m_nport = 0; m_nlast = N - 1; m_ncnt = 0;
    m_popidx = -1;
  endtask

  // Decide this cycle's pop and next output contents from the queue contents.
  task automatic model_eval();
    int w;
    int c;
    int p;
    m_nvalid = m_valid; m_ndata = m_data; m_nport = m_port;
    m_nlast = m_last; m_ncnt = m_cnt; m_popidx = -1;
    if (!rst_n) begin
      m_nvalid = 1'b0; m_ndata = '0; m_nport = 0; m_nlast = N - 1; m_ncnt = 0;
    end else if (!m_valid || ready_r) begin
      w = -1;
      c = 1;
`ifdef ARB_BURST_EN
      if (m_cnt > 0 && m_cnt < MB && fq[m_last].size() > 0) begin
        w = m_last;
        c = m_cnt + 1;
      end
`endif
      for (int k = 1; k <= N; k++) begin
        p = (m_last + k) % N;
        if (w < 0 && fq[p].size() > 0) w = p;
      end
      if (w >= 0) begin
        m_popidx = w; m_nvalid = 1'b1; m_ndata = fq[w][0];
        m_nport = w;  m_nlast = w;     m_ncnt = c;
      end else begin
        m_nvalid = 1'b0;
      end
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      intf.fifo_empty[p] = (fq[p].size() == 0);
      intf.fifo_read_data[p*W +: W] = (fq[p].size() > 0) ? fq[p][0] : '0;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", {31'd0, intf.down_valid}, 32'd0);
    check("rst_data",  {24'd0, intf.down_data},  32'd0);
    check("rst_port",  {30'd0, intf.down_port},  32'd0);
    check("rst_pop",   {28'd0, intf.fifo_pop},   32'd0);
  endtask

  // One clock cycle: commit, apply pushes/ready/reset, then compare at the falling edge.
  task automatic cycle(input logic rdy, input logic rst_v);
    logic [W-1:0] v;
    logic [W-1:0] e;
    int           dp;
    @(posedge clk);
    #1;
    if (m_popidx >= 0 && fq[m_popidx].size() > 0) void'(fq[m_popidx].pop_front());
    m_valid = m_nvalid; m_data = m_ndata; m_port = m_nport; m_last = m_nlast; m_cnt = m_ncnt;
    for (int p = 0; p < N; p++) begin
      while (pend[p].size() > 0) begin
        v = pend[p].pop_front();
        fq[p].push_back(v);
        sb[p].push_back(v);
      end
    end
    ready_r = rdy;
    intf.down_ready = rdy;
    drive();
    if (!rst_v && rst_n) begin
      #2;
      rst_n = 1'b0;
      if (m_valid && sb[m_port].size() > 0) void'(sb[m_port].pop_front());
      model_reset();
      #1;
      check_reset_outputs();
    end else if (rst_v && !rst_n) begin
      rst_n = 1'b1;
    end
    @(negedge clk);
    model_eval();
    check("pop",   {28'd0, intf.fifo_pop}, (m_popidx >= 0) ? (32'd1 << m_popidx) : 32'd0);
    check("valid", {31'd0, intf.down_valid}, {31'd0, m_valid});
    check("data",  {24'd0, intf.down_data},  {24'd0, m_data});
    check("port",  {30'd0, intf.down_port},  m_port);
    if (rst_n && intf.down_valid === 1'b1 && intf.down_ready === 1'b1) begin
      dp = int'(intf.down_port);
      if (dp < N && sb[dp].size() > 0) begin
        e = sb[dp].pop_front();
        check("sb_data", {24'd0, intf.down_data}, {24'd0, e});
      end else begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got beat port %0d data %0h, required no beat", dp, intf.down_data);
      end
    end
  endtask

  int exp3 [8];
  int exp5 [12];
  logic [W-1:0] cap_data;
  logic [1:0]   cap_port;
  int           total;

  initial begin
`ifdef ARB_BURST_EN
    exp3 = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    exp5 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

    // Reset with every FIFO non-empty
    rst_n = 1'b0;
    ready_r = 1'b1;
    intf.down_ready = 1'b1;
    model_reset();
    for (int p = 0; p < N; p++) fq[p].push_back(W'(8'h10 + p));
    drive();
    #2;
    check_reset_outputs();
    @(negedge clk);
    check_reset_outputs();
    for (int p = 0; p < N; p++) fq[p].delete();
    drive();
    model_eval();

    // Single port stream: port 2 holds A1, B2, C3
    pend[2].push_back(8'hA1); pend[2].push_back(8'hB2); pend[2].push_back(8'hC3);
    cycle(1'b1, 1'b1);
    check("t2_pop0", {28'd0, intf.fifo_pop}, 32'h4);
    cycle(1'b1, 1'b1);
    check("t2_pop1", {28'd0, intf.fifo_pop}, 32'h4);
    check("t2_d0", {24'd0, intf.down_data}, 32'hA1);
    check("t2_p0", {30'd0, intf.down_port}, 32'd2);
    cycle(1'b1, 1'b1);
    check("t2_pop2", {28'd0, intf.fifo_pop}, 32'h4);
    check("t2_d1", {24'd0, intf.down_data}, 32'hB2);
    cycle(1'b1, 1'b1);
    check("t2_pop3", {28'd0, intf.fifo_pop}, 32'h0);
    check("t2_d2", {24'd0, intf.down_data}, 32'hC3);
    check("t2_v2", {31'd0, intf.down_valid}, 32'd1);
    cycle(1'b1, 1'b1);
    check("t2_idle", {31'd0, intf.down_valid}, 32'd0);

    // Re-arm rotation at port 0, then all four ports non-empty
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int p = 0; p < N; p++)
      for (int j = 0; j < 2; j++) pend[p].push_back(W'((p << 4) | j));
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1);
      check("t3_port", {30'd0, intf.down_port}, exp3[i]);
      check("t3_valid", {31'd0, intf.down_valid}, 32'd1);
    end
    cycle(1'b1, 1'b1);
    check("t3_idle", {31'd0, intf.down_valid}, 32'd0);

    // Backpressure: five stalled cycles with a beat held
    for (int j = 0; j < 3; j++) begin
      pend[1].push_back(W'(8'h50 + j));
      pend[3].push_back(W'(8'h70 + j));
    end
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cap_data = intf.down_data;
    cap_port = intf.down_port;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle(1'b0, 1'b1);
      check("bp_valid", {31'd0, intf.down_valid}, 32'd1);
      check("bp_pop", {28'd0, intf.fifo_pop}, 32'd0);
      check("bp_data", {24'd0, intf.down_data}, {24'd0, cap_data});
      check("bp_port", {30'd0, intf.down_port}, {30'd0, cap_port});
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    total = 0;
    for (int p = 0; p < N; p++) total += sb[p].size();
    check("bp_no_loss", total, 32'd0);

`ifdef ARB_BURST_EN
    // Burst: ports 0 and 1 with six entries each
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      pend[0].push_back(W'(8'h80 + j));
      pend[1].push_back(W'(8'h90 + j));
    end
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1);
      check("burst_port", {30'd0, intf.down_port}, exp5[i]);
    end
`endif

    // Reset asserted while a beat is held
    for (int p = 1; p < N; p++)
      for (int j = 0; j < 2; j++) pend[p].push_back(W'(8'hC0 + (p << 2) + j));
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    check("mr_held", {31'd0, intf.down_valid}, 32'd1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_reset_outputs();
    cycle(1'b1, 1'b1);
    check("mr_first_pop", {28'd0, intf.fifo_pop}, 32'h2);
    cycle(1'b1, 1'b1);
    check("mr_first_port", {30'd0, intf.down_port}, 32'd1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(99) < 30) pend[p].push_back(W'($urandom));
      cycle(($urandom_range(99) < 70) ? 1'b1 : 1'b0, 1'b1);
    end

    // Drain, bounded
    for (int i = 0; i < 300; i++) begin
      total = 0;
      for (int p = 0; p < N; p++) total += fq[p].size();
      if (total != 0 || m_valid) cycle(1'b1, 1'b1);
    end
    total = 0;
    for (int p = 0; p < N; p++) total += fq[p].size() + sb[p].size();
    check("drain_empty", total, 32'd0);
    check("drain_valid", {31'd0, intf.down_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
